// File: rtl/branch_trace_pkg.sv
// Shared types for the branch trace recorder: trace word, FIFO event entry and
// record-writer FSM states.
package branch_trace_pkg;

    localparam int unsigned WORDS_PER_RECORD = 3;
    localparam int unsigned TRACE_W          = 65;
    localparam int unsigned XLEN             = 32;

    typedef logic [TRACE_W-1:0] trace_word_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            taken;
        logic            pred;
    } trace_event_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_PC,
        ST_WR_TGT,
        ST_WR_RES,
        ST_DONE
    } rec_state_e;

    // Zero-extend a 32-bit field into one trace memory word.
    function automatic trace_word_t to_word(input logic [XLEN-1:0] v);
        return {(TRACE_W - XLEN)'(0), v};
    endfunction

endpackage

// File: rtl/branch_trace_recorder_fifo.sv
// trace_event_fifo: small synchronous FIFO of branch events with a flush that
// can coexist with a same-cycle push (the pushed entry survives the flush).
module trace_event_fifo
    import branch_trace_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_flush,
    input  logic         i_push,
    input  trace_event_t i_push_data,
    input  logic         i_pop,
    output trace_event_t o_pop_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    trace_event_t     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_pop_data = r_mem[r_rd_ptr];

    // A full FIFO refuses a push even if it is popped in the same cycle.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty & ~i_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= PTR_W'(w_push);
            r_rd_ptr <= '0;
            r_count  <= CNT_W'(w_push);
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[i_flush ? PTR_W'(0) : r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/branch_trace_recorder.sv
// branch_trace_recorder: buffers resolved-branch events and writes them as
// PC/target/result word triples into trace memory. Optional statistics: TRACE_STATS_EN.
module branch_trace_recorder
    import branch_trace_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 5376,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ev_valid,
    output logic              ev_ready,
    input  logic [31:0]       ev_pc,
    input  logic [31:0]       ev_target,
    input  logic              ev_taken,
    input  logic              ev_pred,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output trace_word_t       mem_wdata,
    output logic              mem_full,
    output logic [15:0]       rec_count,
    output logic [15:0]       drop_count,
    output logic [31:0]       hit_count,
    output logic [31:0]       event_count
);

    rec_state_e        r_state;
    rec_state_e        w_next_state;
    logic [ADDR_W-1:0] r_wr_addr;
    trace_event_t      r_hold;
    logic [15:0]       r_rec_count;
    logic [15:0]       r_drop_count;

    trace_event_t w_push_ev;
    trace_event_t w_fifo_out;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    logic         w_clear;
    logic         w_pop;
    logic         w_load;
    logic         w_drop;
    logic         w_rec_done;
    logic         w_fits_now;
    logic         w_fits_next;
    logic         w_full_next;
    logic         w_at_end;

    // Room checks for a record starting at wr_addr now, or after this word2 write.
    assign w_fits_now  = (32'(r_wr_addr) + 32'(WORDS_PER_RECORD)) <= 32'(DEPTH_WORDS);
    assign w_fits_next = (32'(r_wr_addr) + 32'(WORDS_PER_RECORD) + 32'd1) <= 32'(DEPTH_WORDS);
    assign w_full_next = (32'(r_wr_addr) + 32'd1) == 32'(DEPTH_WORDS);
    assign w_at_end    = 32'(r_wr_addr) == 32'(DEPTH_WORDS);
    assign w_clear     = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));

    always_comb begin
        w_push_ev        = '0;
        w_push_ev.pc     = ev_pc;
        w_push_ev.target = ev_target;
        w_push_ev.taken  = ev_taken;
`ifdef TRACE_STATS_EN
        w_push_ev.pred   = ev_pred;
`endif
    end

    trace_event_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (w_clear),
        .i_push      (ev_valid),
        .i_push_data (w_push_ev),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_out),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign ev_ready = ~w_fifo_full;
    assign mem_addr = r_wr_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_clear)                        w_next_state = ST_IDLE;
                else if (!w_fifo_empty && w_fits_now) w_next_state = ST_WR_PC;
                else if (w_at_end)                  w_next_state = ST_DONE;
            end
            ST_WR_PC:  w_next_state = ST_WR_TGT;
            ST_WR_TGT: w_next_state = ST_WR_RES;
            ST_WR_RES: begin
                if (!w_fifo_empty && w_fits_next) w_next_state = ST_WR_PC;
                else if (w_full_next)             w_next_state = ST_DONE;
                else                              w_next_state = ST_IDLE;
            end
            ST_DONE: begin
                if (w_clear) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_we     = 1'b0;
        mem_wdata  = '0;
        mem_full   = 1'b0;
        w_pop      = 1'b0;
        w_load     = 1'b0;
        w_drop     = 1'b0;
        w_rec_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load = ~w_clear & ~w_fifo_empty & w_fits_now;
                w_pop  = w_load;
            end
            ST_WR_PC: begin
                mem_we    = 1'b1;
                mem_wdata = to_word(r_hold.pc);
            end
            ST_WR_TGT: begin
                mem_we    = 1'b1;
                mem_wdata = to_word(r_hold.target);
            end
            ST_WR_RES: begin
                mem_we     = 1'b1;
                mem_wdata  = {(TRACE_W - 1)'(0), r_hold.taken};
                w_rec_done = 1'b1;
                w_load     = ~w_fifo_empty & w_fits_next;
                w_pop      = w_load;
            end
            ST_DONE: begin
                mem_full = 1'b1;
                w_drop   = ~w_clear & ~w_fifo_empty;
                w_pop    = w_drop;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_addr    <= '0;
            r_hold       <= '0;
            r_rec_count  <= '0;
            r_drop_count <= '0;
        end else if (w_clear) begin
            r_wr_addr    <= '0;
            r_rec_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_load) r_hold <= w_fifo_out;
            if (mem_we) r_wr_addr <= r_wr_addr + ADDR_W'(1);
            if (w_rec_done && r_rec_count != '1)  r_rec_count  <= r_rec_count + 16'd1;
            if (w_drop && r_drop_count != '1)     r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign rec_count  = r_rec_count;
    assign drop_count = r_drop_count;

`ifdef TRACE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_event_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_count   <= '0;
            r_event_count <= '0;
        end else if (w_clear) begin
            r_hit_count   <= '0;
            r_event_count <= '0;
        end else if (w_rec_done) begin
            if (r_event_count != '1) r_event_count <= r_event_count + 32'd1;
            if ((r_hold.pred == r_hold.taken) && r_hit_count != '1)
                r_hit_count <= r_hit_count + 32'd1;
        end
    end

    assign hit_count   = r_hit_count;
    assign event_count = r_event_count;
`else
    logic w_unused;
    assign w_unused    = ^{ev_pred, r_hold.pred};
    assign hit_count   = '0;
    assign event_count = '0;
`endif

endmodule
